// File: rtl/rgb_led_sched_if.sv
// rgb_led_sched_if: requester/colour inputs and grant/duty/status outputs of the LED scheduler
interface rgb_led_sched_if #(parameter int N_REQ = 4);
    logic [N_REQ-1:0]    req_i;
    logic [24*N_REQ-1:0] color_i;
    logic [N_REQ-1:0]    gnt_o;
    logic [7:0]          R_duty_o;
    logic [7:0]          G_duty_o;
    logic [7:0]          B_duty_o;
    logic                tick_o;
    logic                fading_o;
    logic                idle_o;
    modport master (output req_i, color_i,
                    input  gnt_o, R_duty_o, G_duty_o, B_duty_o, tick_o, fading_o, idle_o);
    modport slave  (input  req_i, color_i,
                    output gnt_o, R_duty_o, G_duty_o, B_duty_o, tick_o, fading_o, idle_o);
endinterface

// File: rtl/rgb_led_sched.sv
// rgb_led_sched: round-robin owner of the RGB LED with minimum hold time and per-channel duty sequencing.
// Define RGB_SCHED_FADE_EN to step duties by 1 per tick instead of following the target every cycle.
module rgb_led_sched #(
    parameter int N_REQ      = 4,
    parameter int TICK_DIV   = 65536,
    parameter int HOLD_TICKS = 256
) (
    input logic          clk_24MHz_i,
    input logic          rst_i,
    rgb_led_sched_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TICK_DIV);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    typedef enum logic {IDLE, OWN} state_t;
    state_t           state_q, nxt_state;
    logic [CW-1:0]    cnt_q;
    logic             tick_q;
    logic [N_REQ-1:0] gnt_q, nxt_gnt, others;
    logic [IW-1:0]    last_q, nxt_last;
    logic [HW-1:0]    hold_q, nxt_hold;
    logic [23:0]      duty_q, nxt_duty, tgt;
    logic             owner_req;
    // lowest offset from last+1 wins; offset N_REQ (last itself) has the lowest priority
    function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [IW-1:0] last);
        logic [IW-1:0] p;
        p = last;
        for (int i = N_REQ; i >= 1; i--) begin
            if (r[(int'(last) + i) % N_REQ]) p = IW'((int'(last) + i) % N_REQ);
        end
        return p;
    endfunction
    function automatic logic [7:0] step(input logic [7:0] d, input logic [7:0] t);
        return (d < t) ? d + 8'd1 : (d > t) ? d - 8'd1 : d;
    endfunction
    assign others    = bus.req_i & ~gnt_q;
    assign owner_req = |(bus.req_i & gnt_q);
    assign tgt       = (state_q == OWN) ? bus.color_i[24*int'(last_q) +: 24] : 24'h000000;
    always_comb begin
        nxt_state = state_q;
        nxt_last  = last_q;
        nxt_hold  = hold_q;
        if (state_q == IDLE) begin
            if (|bus.req_i) begin
                nxt_state = OWN;
                nxt_last  = rr_pick(bus.req_i, last_q);
                nxt_hold  = '0;
            end
        end else if (!owner_req) begin
            nxt_state = (|others) ? OWN : IDLE;
            nxt_last  = (|others) ? rr_pick(others, last_q) : last_q;
            nxt_hold  = '0;
        end else if (hold_q == HW'(HOLD_TICKS) && |others) begin
            nxt_last = rr_pick(others, last_q);
            nxt_hold = '0;
        end else if (tick_q && hold_q != HW'(HOLD_TICKS)) begin
            nxt_hold = hold_q + 1'b1;
        end
        nxt_gnt = (nxt_state == OWN) ? N_REQ'(1) << nxt_last : '0;
`ifdef RGB_SCHED_FADE_EN
        nxt_duty = tick_q ? {step(duty_q[23:16], tgt[23:16]), step(duty_q[15:8], tgt[15:8]),
                             step(duty_q[7:0], tgt[7:0])} : duty_q;
`else
        nxt_duty = tgt;
`endif
    end
    always_ff @(posedge clk_24MHz_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= IW'(N_REQ - 1);
            hold_q  <= '0;
            duty_q  <= '0;
        end else begin
            cnt_q   <= (cnt_q == CW'(TICK_DIV - 1)) ? '0 : cnt_q + 1'b1;
            tick_q  <= (cnt_q == CW'(TICK_DIV - 2));
            state_q <= nxt_state;
            gnt_q   <= nxt_gnt;
            last_q  <= nxt_last;
            hold_q  <= nxt_hold;
            duty_q  <= nxt_duty;
        end
    end
    assign bus.gnt_o    = gnt_q;
    assign bus.R_duty_o = duty_q[23:16];
    assign bus.G_duty_o = duty_q[15:8];
    assign bus.B_duty_o = duty_q[7:0];
    assign bus.tick_o   = tick_q;
    assign bus.fading_o = (duty_q != tgt);
    assign bus.idle_o   = (state_q == IDLE) && (duty_q == 24'h000000);
endmodule

// File: tb/tb_rgb_led_sched.sv
// tb_rgb_led_sched: directed scenario tasks for rgb_led_sched with N_REQ=4, TICK_DIV=4, HOLD_TICKS=3
module tb_rgb_led_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   ec = -1;
    rgb_led_sched_if #(.N_REQ(4)) bus ();
    rgb_led_sched #(.N_REQ(4), .TICK_DIV(4), .HOLD_TICKS(3)) dut (
        .clk_24MHz_i(clk),
        .rst_i      (rst),
        .bus        (bus)
    );
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            ec++;
        end
    endtask
    task automatic wait_edge(input int k);
        while (ec < k) cyc(1);
    endtask
    // edge e0 is the first edge with reset released; ec tracks the last edge passed
    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        ec = -1;
    endtask
    task automatic test_reset();
        bus.req_i = 4'b1111;
        bus.color_i = {24'h445566, 24'h332211, 24'h112233, 24'hABCDEF};
        rst = 1'b1;
        cyc(2);
        checks++; if (bus.gnt_o !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt_o); end
        checks++; if ({bus.R_duty_o, bus.G_duty_o, bus.B_duty_o} !== 24'h000000) begin failures++; $display("FAIL reset_duty got=%h exp=000000", {bus.R_duty_o, bus.G_duty_o, bus.B_duty_o}); end
        checks++; if (bus.tick_o !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", bus.tick_o); end
        checks++; if (bus.idle_o !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", bus.idle_o); end
        bus.req_i = 4'b0000;
        rst = 1'b0;
        ec = -1;
        wait_edge(1);
        checks++; if (bus.tick_o !== 1'b0) begin failures++; $display("FAIL tick_early got=%b exp=0", bus.tick_o); end
        wait_edge(2);
        checks++; if (bus.tick_o !== 1'b1) begin failures++; $display("FAIL tick_first got=%b exp=1", bus.tick_o); end
        wait_edge(3);
        checks++; if (bus.tick_o !== 1'b0) begin failures++; $display("FAIL tick_width got=%b exp=0", bus.tick_o); end
    endtask
    task automatic test_rotation();
        bus.req_i = 4'b1010;
        bus.color_i = {24'h445566, 24'h000000, 24'h112233, 24'h000000};
        do_reset();
        cyc(1);
        checks++; if (bus.gnt_o !== 4'b0010) begin failures++; $display("FAIL rot_first got=%b exp=0010", bus.gnt_o); end
        while (ec < 24) begin
            cyc(1);
            checks++; if (!$onehot0(bus.gnt_o)) begin failures++; $display("FAIL rot_onehot edge=%0d got=%b", ec, bus.gnt_o); end
`ifndef RGB_SCHED_FADE_EN
            if (ec == 1) begin
                checks++; if ({bus.R_duty_o, bus.G_duty_o, bus.B_duty_o} !== 24'h112233) begin failures++; $display("FAIL rot_duty1 got=%h exp=112233", {bus.R_duty_o, bus.G_duty_o, bus.B_duty_o}); end
            end
            if (ec == 13) begin
                checks++; if ({bus.R_duty_o, bus.G_duty_o, bus.B_duty_o} !== 24'h445566) begin failures++; $display("FAIL rot_duty3 got=%h exp=445566", {bus.R_duty_o, bus.G_duty_o, bus.B_duty_o}); end
            end
`endif
            if (ec == 11) begin
                checks++; if (bus.gnt_o !== 4'b0010) begin failures++; $display("FAIL rot_hold1 got=%b exp=0010", bus.gnt_o); end
            end
            if (ec == 12) begin
                checks++; if (bus.gnt_o !== 4'b1000) begin failures++; $display("FAIL rot_to3 got=%b exp=1000", bus.gnt_o); end
            end
            if (ec == 23) begin
                checks++; if (bus.gnt_o !== 4'b1000) begin failures++; $display("FAIL rot_hold3 got=%b exp=1000", bus.gnt_o); end
            end
            if (ec == 24) begin
                checks++; if (bus.gnt_o !== 4'b0010) begin failures++; $display("FAIL rot_back got=%b exp=0010", bus.gnt_o); end
            end
        end
    endtask
    task automatic test_owner_drop();
        bus.req_i = 4'b0101;
        bus.color_i = {24'h000000, 24'h000000, 24'h000000, 24'h0A0B0C};
        do_reset();
        wait_edge(0);
        checks++; if (bus.gnt_o !== 4'b0001) begin failures++; $display("FAIL drop_first got=%b exp=0001", bus.gnt_o); end
        wait_edge(7);
        bus.req_i = 4'b0100;
        wait_edge(8);
        checks++; if (bus.gnt_o !== 4'b0100) begin failures++; $display("FAIL drop_switch got=%b exp=0100", bus.gnt_o); end
        bus.req_i = 4'b0101;
        wait_edge(19);
        checks++; if (bus.gnt_o !== 4'b0100) begin failures++; $display("FAIL drop_hold_reset got=%b exp=0100", bus.gnt_o); end
        wait_edge(20);
        checks++; if (bus.gnt_o !== 4'b0001) begin failures++; $display("FAIL drop_rotate got=%b exp=0001", bus.gnt_o); end
        bus.req_i = 4'b0000;
        wait_edge(21);
        checks++; if (bus.gnt_o !== 4'b0000) begin failures++; $display("FAIL drop_idle_gnt got=%b exp=0000", bus.gnt_o); end
`ifndef RGB_SCHED_FADE_EN
        checks++; if (bus.idle_o !== 1'b0 || bus.fading_o !== 1'b1) begin failures++; $display("FAIL drop_release got idle=%b fading=%b exp idle=0 fading=1", bus.idle_o, bus.fading_o); end
        wait_edge(22);
        checks++; if (bus.idle_o !== 1'b1 || bus.R_duty_o !== 8'h00) begin failures++; $display("FAIL drop_idle got idle=%b R=%h exp idle=1 R=00", bus.idle_o, bus.R_duty_o); end
`endif
    endtask
    task automatic test_sole_owner();
        bus.req_i = 4'b0001;
        do_reset();
        wait_edge(20);
        checks++; if (bus.gnt_o !== 4'b0001) begin failures++; $display("FAIL sole_keep got=%b exp=0001", bus.gnt_o); end
        bus.req_i = 4'b0011;
        wait_edge(21);
        checks++; if (bus.gnt_o !== 4'b0010) begin failures++; $display("FAIL sole_preempt got=%b exp=0010", bus.gnt_o); end
    endtask
`ifdef RGB_SCHED_FADE_EN
    task automatic test_fade();
        bus.req_i = 4'b0001;
        bus.color_i = {72'h0, 24'h030201};
        do_reset();
        wait_edge(0);
        checks++; if (bus.gnt_o !== 4'b0001) begin failures++; $display("FAIL fade_gnt got=%b exp=0001", bus.gnt_o); end
        wait_edge(3);
        checks++; if ({bus.R_duty_o, bus.G_duty_o, bus.B_duty_o} !== 24'h010101) begin failures++; $display("FAIL fade_t1 got=%h exp=010101", {bus.R_duty_o, bus.G_duty_o, bus.B_duty_o}); end
        wait_edge(7);
        checks++; if ({bus.R_duty_o, bus.G_duty_o, bus.B_duty_o} !== 24'h020201 || bus.fading_o !== 1'b1) begin failures++; $display("FAIL fade_t2 got=%h fading=%b exp=020201 fading=1", {bus.R_duty_o, bus.G_duty_o, bus.B_duty_o}, bus.fading_o); end
        wait_edge(11);
        checks++; if ({bus.R_duty_o, bus.G_duty_o, bus.B_duty_o} !== 24'h030201 || bus.fading_o !== 1'b0) begin failures++; $display("FAIL fade_t3 got=%h fading=%b exp=030201 fading=0", {bus.R_duty_o, bus.G_duty_o, bus.B_duty_o}, bus.fading_o); end
    endtask
    task automatic test_fade_release();
        bus.req_i = 4'b0001;
        bus.color_i = {72'h0, 24'h020000};
        do_reset();
        wait_edge(7);
        checks++; if (bus.R_duty_o !== 8'h02) begin failures++; $display("FAIL rel_start got=%h exp=02", bus.R_duty_o); end
        bus.req_i = 4'b0000;
        wait_edge(8);
        checks++; if (bus.gnt_o !== 4'b0000) begin failures++; $display("FAIL rel_gnt got=%b exp=0000", bus.gnt_o); end
        wait_edge(11);
        checks++; if (bus.R_duty_o !== 8'h01 || bus.idle_o !== 1'b0) begin failures++; $display("FAIL rel_t1 got R=%h idle=%b exp R=01 idle=0", bus.R_duty_o, bus.idle_o); end
        wait_edge(15);
        checks++; if (bus.R_duty_o !== 8'h00 || bus.idle_o !== 1'b1) begin failures++; $display("FAIL rel_t2 got R=%h idle=%b exp R=00 idle=1", bus.R_duty_o, bus.idle_o); end
    endtask
`else
    task automatic test_color_follow();
        bus.req_i = 4'b0001;
        bus.color_i = {72'h0, 24'h000000};
        do_reset();
        wait_edge(1);
        checks++; if ({bus.R_duty_o, bus.G_duty_o, bus.B_duty_o} !== 24'h000000) begin failures++; $display("FAIL follow_zero got=%h exp=000000", {bus.R_duty_o, bus.G_duty_o, bus.B_duty_o}); end
        bus.color_i = {72'h0, 24'hFF0080};
        #1;
        checks++; if (bus.fading_o !== 1'b1) begin failures++; $display("FAIL follow_fading got=%b exp=1", bus.fading_o); end
        wait_edge(2);
        checks++; if ({bus.R_duty_o, bus.G_duty_o, bus.B_duty_o} !== 24'hFF0080 || bus.fading_o !== 1'b0) begin failures++; $display("FAIL follow_duty got=%h fading=%b exp=FF0080 fading=0", {bus.R_duty_o, bus.G_duty_o, bus.B_duty_o}, bus.fading_o); end
        rst = 1'b1;
        cyc(1);
        checks++; if (bus.gnt_o !== 4'b0000 || {bus.R_duty_o, bus.G_duty_o, bus.B_duty_o} !== 24'h000000 || bus.tick_o !== 1'b0 || bus.idle_o !== 1'b1) begin failures++; $display("FAIL midrst got gnt=%b duty=%h tick=%b idle=%b exp 0000/000000/0/1", bus.gnt_o, {bus.R_duty_o, bus.G_duty_o, bus.B_duty_o}, bus.tick_o, bus.idle_o); end
        rst = 1'b0;
    endtask
`endif
    initial begin
        bus.req_i = '0;
        bus.color_i = '0;
        test_reset();
        test_rotation();
        test_owner_drop();
        test_sole_owner();
`ifdef RGB_SCHED_FADE_EN
        test_fade();
        test_fade_release();
`else
        test_color_follow();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
